// File: rtl/chacha_pkg.sv
// Shared definitions for the ChaCha block core: constants, FSM states,
// quarter-round index tables and bus-width helpers.
package chacha_pkg;

  // "expand 32-byte k" as four little-endian words.
  localparam logic [31:0] SIGMA0 = 32'h61707865;
  localparam logic [31:0] SIGMA1 = 32'h3320646e;
  localparam logic [31:0] SIGMA2 = 32'h79622d32;
  localparam logic [31:0] SIGMA3 = 32'h6b206574;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_ROUND,
    ST_ADD,
    ST_READY
  } state_e;

  // Word indices for each of the eight quarter-round steps of a double
  // round: steps 0-3 are the columns, steps 4-7 the diagonals.
  // Element [n] of each packed table belongs to step n.
  localparam logic [7:0][3:0] QR_A = {4'd3,  4'd2,  4'd1,  4'd0,  4'd3,  4'd2,  4'd1,  4'd0};
  localparam logic [7:0][3:0] QR_B = {4'd4,  4'd7,  4'd6,  4'd5,  4'd7,  4'd6,  4'd5,  4'd4};
  localparam logic [7:0][3:0] QR_C = {4'd9,  4'd8,  4'd11, 4'd10, 4'd11, 4'd10, 4'd9,  4'd8};
  localparam logic [7:0][3:0] QR_D = {4'd14, 4'd13, 4'd12, 4'd15, 4'd15, 4'd14, 4'd13, 4'd12};

  // Number of bus transfers needed to move a field of field_bits bits.
  function automatic int chunk_count(input int field_bits, input int bus_w);
    return field_bits / bus_w;
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

endpackage

// File: rtl/chacha_qr.sv
// Combinational ChaCha quarter-round on four 32-bit words.
module chacha_qr
  import chacha_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] c_i,
  input  logic [31:0] d_i,
  output logic [31:0] a_o,
  output logic [31:0] b_o,
  output logic [31:0] c_o,
  output logic [31:0] d_o
);

  logic [31:0] a1, b1, c1, d1;
  logic [31:0] a2, b2, c2, d2;

  // First half: rotate by 16 then 12.
  assign a1 = a_i + b_i;
  assign d1 = rotl(d_i ^ a1, 16);
  assign c1 = c_i + d1;
  assign b1 = rotl(b_i ^ c1, 12);

  // Second half: rotate by 8 then 7.
  assign a2 = a1 + b1;
  assign d2 = rotl(d1 ^ a2, 8);
  assign c2 = c1 + d2;
  assign b2 = rotl(b1 ^ c2, 7);

  assign a_o = a2;
  assign b_o = b2;
  assign c_o = c2;
  assign d_o = d2;

endmodule

// File: rtl/chacha_core.sv
// ChaCha (RFC 8439) keystream block generator with a narrow host bus.
// Key, nonce and counter are loaded in BUS_W-bit little-endian chunks; a
// falling edge on wr_ctr starts a block, computed one quarter-round per
// cycle, then read out chunk by chunk in RFC byte order.
// Optional build macro CHACHA_AUTO_NEXT_EN: after the last chunk of a block
// is read, the next block (counter + 1) is started without host action.
module chacha_core
  import chacha_pkg::*;
#(
  parameter int ROUNDS = 20,
  parameter int BUS_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_key,
  input  logic             wr_nnc,
  input  logic             wr_ctr,
  input  logic [BUS_W-1:0] data_in,
  input  logic             rd_blk,
  output logic             blk_ready,
  output logic [BUS_W-1:0] data_out,
  output logic             busy
);

  localparam int KEY_N = chunk_count(256, BUS_W);
  localparam int NNC_N = chunk_count(96, BUS_W);
  localparam int CTR_N = chunk_count(32, BUS_W);
  localparam int BLK_N = chunk_count(512, BUS_W);

  localparam logic [5:0] KEY_LAST = 6'(KEY_N - 1);
  localparam logic [5:0] NNC_LAST = 6'(NNC_N - 1);
  localparam logic [5:0] CTR_LAST = 6'(CTR_N - 1);
  localparam logic [5:0] BLK_LAST = 6'(BLK_N - 1);
  localparam logic [7:0] QR_LAST  = 8'(4 * ROUNDS - 1);

  // Host-loaded parameters
  logic [255:0] key_q, key_d;
  logic [95:0]  nonce_q, nonce_d;
  logic [31:0]  ctr_q, ctr_d;

  // Chunk write indices and previous-cycle write enables
  logic [5:0] key_idx_q, key_idx_d;
  logic [5:0] nnc_idx_q, nnc_idx_d;
  logic [5:0] ctr_idx_q, ctr_idx_d;
  logic       key_we_q, nnc_we_q, ctr_we_q;
  logic       wr_ctr_q;

  // Block computation
  state_e            state_q, state_d;
  logic [15:0][31:0] work_q, work_d;
  logic [511:0]      blk_q, blk_d;
  logic [7:0]        qr_cnt_q, qr_cnt_d;
  logic [5:0]        rd_ptr_q, rd_ptr_d;

  logic              key_we, nnc_we, ctr_we, any_wr, ctr_fall, ctr_inc;
  logic [5:0]        key_pos, nnc_pos, ctr_pos;
  logic [15:0][31:0] init_w;
  logic [2:0]        step;
  logic [3:0]        ia, ib, ic, id;
  logic [31:0]       qa, qb, qc, qd;

  // Strobe priority: key over nonce over counter.
  assign key_we   = wr_key;
  assign nnc_we   = wr_nnc & ~wr_key;
  assign ctr_we   = wr_ctr & ~wr_key & ~wr_nnc;
  assign any_wr   = wr_key | wr_nnc | wr_ctr;
  assign ctr_fall = wr_ctr_q & ~wr_ctr;

  // A strobe that was low last cycle restarts its field at chunk 0.
  assign key_pos = key_we_q ? key_idx_q : 6'd0;
  assign nnc_pos = nnc_we_q ? nnc_idx_q : 6'd0;
  assign ctr_pos = ctr_we_q ? ctr_idx_q : 6'd0;

  // Input state as defined by RFC 8439: constants, key, counter, nonce.
  always_comb begin
    init_w[0] = SIGMA0;
    init_w[1] = SIGMA1;
    init_w[2] = SIGMA2;
    init_w[3] = SIGMA3;
    for (int i = 0; i < 8; i++) init_w[4 + i] = key_q[32 * i +: 32];
    init_w[12] = ctr_q;
    for (int i = 0; i < 3; i++) init_w[13 + i] = nonce_q[32 * i +: 32];
  end

  // Quarter-round operand selection for the current step.
  assign step = qr_cnt_q[2:0];
  assign ia   = QR_A[step];
  assign ib   = QR_B[step];
  assign ic   = QR_C[step];
  assign id   = QR_D[step];

  chacha_qr u_qr (
    .a_i (work_q[ia]),
    .b_i (work_q[ib]),
    .c_i (work_q[ic]),
    .d_i (work_q[id]),
    .a_o (qa),
    .b_o (qb),
    .c_o (qc),
    .d_o (qd)
  );

  // Host writes into key/nonce/counter; counter also advances after a block is read.
  always_comb begin
    // NOTE: every variable this block drives gets a default first, so no path can infer a latch.
    key_d     = key_q;
    nonce_d   = nonce_q;
    ctr_d     = ctr_q;
    key_idx_d = key_idx_q;
    nnc_idx_d = nnc_idx_q;
    ctr_idx_d = ctr_idx_q;
    if (key_we) begin
      key_d[key_pos * BUS_W +: BUS_W] = data_in;
      key_idx_d = (key_pos == KEY_LAST) ? 6'd0 : key_pos + 6'd1;
    end
    if (nnc_we) begin
      nonce_d[nnc_pos * BUS_W +: BUS_W] = data_in;
      nnc_idx_d = (nnc_pos == NNC_LAST) ? 6'd0 : nnc_pos + 6'd1;
    end
    if (ctr_we) begin
      ctr_d[ctr_pos * BUS_W +: BUS_W] = data_in;
      ctr_idx_d = (ctr_pos == CTR_LAST) ? 6'd0 : ctr_pos + 6'd1;
    end else if (ctr_inc) begin
      ctr_d = ctr_q + 32'd1;
    end
  end

  // FSM next state plus working/block register updates.
  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    blk_d    = blk_q;
    qr_cnt_d = qr_cnt_q;
    rd_ptr_d = rd_ptr_q;
    ctr_inc  = 1'b0;

    case (state_q)
      ST_IDLE: ;
      ST_INIT: begin
        work_d   = init_w;
        qr_cnt_d = 8'd0;
        rd_ptr_d = 6'd0;
        state_d  = ST_ROUND;
      end
      ST_ROUND: begin
        work_d[ia] = qa;
        work_d[ib] = qb;
        work_d[ic] = qc;
        work_d[id] = qd;
        qr_cnt_d   = qr_cnt_q + 8'd1;
        if (qr_cnt_q == QR_LAST) state_d = ST_ADD;
      end
      ST_ADD: begin
        for (int i = 0; i < 16; i++) blk_d[32 * i +: 32] = work_q[i] + init_w[i];
        rd_ptr_d = 6'd0;
        state_d  = ST_READY;
      end
      ST_READY: begin
        if (rd_blk) begin
          if (rd_ptr_q == BLK_LAST) begin
            rd_ptr_d = 6'd0;
            ctr_inc  = 1'b1;
`ifdef CHACHA_AUTO_NEXT_EN
            state_d  = ST_INIT;
`else
            state_d  = ST_IDLE;
`endif
          end else begin
            rd_ptr_d = rd_ptr_q + 6'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Host activity overrides whatever the block pipeline wanted to do.
    if (any_wr) begin
      if (state_q != ST_IDLE) begin
        state_d  = ST_IDLE;
        rd_ptr_d = 6'd0;
      end
      ctr_inc = 1'b0;
    end else if (ctr_fall) begin
      state_d  = ST_INIT;
      rd_ptr_d = 6'd0;
      ctr_inc  = 1'b0;
    end
  end

  // Register update with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (rst) begin
      // NOTE: working and block state are flops rather than RAM, so they are cleared too;
      // nothing from a previous keystream survives a reset.
      key_q     <= '0;
      nonce_q   <= '0;
      ctr_q     <= '0;
      key_idx_q <= '0;
      nnc_idx_q <= '0;
      ctr_idx_q <= '0;
      key_we_q  <= 1'b0;
      nnc_we_q  <= 1'b0;
      ctr_we_q  <= 1'b0;
      wr_ctr_q  <= 1'b0;
      state_q   <= ST_IDLE;
      work_q    <= '0;
      blk_q     <= '0;
      qr_cnt_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      key_q     <= key_d;
      nonce_q   <= nonce_d;
      ctr_q     <= ctr_d;
      key_idx_q <= key_idx_d;
      nnc_idx_q <= nnc_idx_d;
      ctr_idx_q <= ctr_idx_d;
      key_we_q  <= key_we;
      nnc_we_q  <= nnc_we;
      ctr_we_q  <= ctr_we;
      wr_ctr_q  <= wr_ctr;
      state_q   <= state_d;
      work_q    <= work_d;
      blk_q     <= blk_d;
      qr_cnt_q  <= qr_cnt_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  assign blk_ready = (state_q == ST_READY);
  assign busy      = (state_q == ST_INIT) || (state_q == ST_ROUND) || (state_q == ST_ADD);
  assign data_out  = blk_ready ? blk_q[rd_ptr_q * BUS_W +: BUS_W] : '0;

endmodule

// File: doc/chacha_core.md
CHACHA_CORE -- requirements
Module: chacha_core

Interface
REQ-001 SHALL have parameter ROUNDS, default 20, total ChaCha rounds; legal 8, 12, 20.
REQ-002 SHALL have parameter BUS_W, default 8, data bus width in bits; legal 8, 16, 32.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 wr_key  input  1  high: write one key chunk per cycle from data_in.
REQ-006 wr_nnc  input  1  high: write one nonce chunk per cycle.
REQ-007 wr_ctr  input  1  high: write one counter chunk per cycle.
REQ-008 data_in  input  BUS_W  key/nonce/counter chunk, little-endian byte order.
REQ-009 rd_blk  input  1  high with blk_ready: consume one output chunk per cycle.
REQ-010 blk_ready  output  1  keystream block available for reading.
REQ-011 data_out  output  BUS_W  current keystream chunk; 0 when blk_ready low.
REQ-012 busy  output  1  block computation in progress.

Function
REQ-013 SHALL implement ChaCha per RFC 8439: 256-bit key, 96-bit nonce, 32-bit counter, constants "expand 32-byte k".
REQ-014 Each write strobe SHALL restart its chunk index at 0 on its first high cycle and advance by one per high cycle.
- Index wraps after 256/BUS_W (key), 96/BUS_W (nonce), or 32/BUS_W (counter) chunks.
- On a partial write, unwritten chunks SHALL keep their old values.
REQ-015 If more than one write strobe is high in the same cycle, priority SHALL be wr_key > wr_nnc > wr_ctr; lower-priority strobes are ignored that cycle.
REQ-016 FSM states IDLE, INIT, ROUND, ADD, READY.
REQ-017 Falling edge of wr_ctr (high previous cycle, low now) SHALL move any state to INIT.
REQ-018 INIT: load working state from constants, key, counter, and nonce; 1 cycle.
REQ-019 ROUND: one quarter-round per cycle, ordered columns 0-3 then diagonals 0-3; lasts 4*ROUNDS cycles.
REQ-020 ADD: add input state to working state (mod 2^32) into the block register; 1 cycle; then READY.
REQ-021 Latency from the wr_ctr falling edge to blk_ready high SHALL be 4*ROUNDS+2 cycles (82 for ROUNDS=20).
REQ-022 busy SHALL be high in INIT, ROUND, and ADD only.
REQ-023 In READY, data_out SHALL present block chunk rd_ptr combinationally, serialised in RFC byte order.
- rd_ptr advances on each cycle where rd_blk is high.
REQ-024 After the last chunk (512/BUS_W) is consumed, the counter SHALL increment (wrapping 0xFFFFFFFF to 0).
- blk_ready SHALL go low on the next cycle.
REQ-025 rd_blk while blk_ready is low SHALL be ignored.
REQ-026 Any write strobe during INIT, ROUND, ADD, or READY SHALL abort to IDLE and drop blk_ready, except the wr_ctr falling edge, which restarts per REQ-017.

Reset
REQ-027 rst SHALL clear the key, nonce, counter, working and block registers, and pointers to 0, and set state to IDLE, blk_ready 0, busy 0, data_out 0; reset applies mid-operation.

Configuration
REQ-028 With CHACHA_AUTO_NEXT_EN defined: after the last chunk is read, the FSM SHALL enter INIT with the incremented counter.
- The next block becomes ready 4*ROUNDS+2 cycles later with no host write.
REQ-029 Without CHACHA_AUTO_NEXT_EN: after the last chunk the FSM SHALL go to IDLE and wait for a wr_ctr falling edge; the counter still increments.

Structure
REQ-030 Package chacha_pkg SHALL hold:
- the four constant words;
- the FSM state enum;
- quarter-round index tables (a,b,c,d per QR step);
- a function computing chunk count from BUS_W.
REQ-031 Sub-module chacha_qr SHALL be the combinational quarter-round (four 32-bit in, four out).

Verification
REQ-032 RFC 8439 sec 2.3.2 vector: key 00..1f, nonce 00 00 00 09 00 00 00 4a 00 00 00 00, counter 1.
- Expected first bytes 10 f1 e7 e4 d1 3b 59 15; blk_ready at cycle 82.
- Run at BUS_W 8, 16, and 32.
REQ-033 Counter 0xFFFFFFFF, read full block -> internal counter 0.
- With CHACHA_AUTO_NEXT_EN, the second block equals the block for counter 0.
REQ-034 Without CHACHA_AUTO_NEXT_EN, read full block -> blk_ready 0 and busy 0 until a new wr_ctr.
REQ-035 wr_key asserted at ROUND cycle 10 -> state IDLE, busy 0, blk_ready stays 0.
REQ-036 rst at READY mid-read (rd_ptr 20) -> next cycle blk_ready 0, data_out 0.
- Rewriting all inputs then gives a correct block.
REQ-037 ROUNDS=8 and 12 against reference model outputs -> blk_ready after 34 and 50 cycles respectively.
